// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat carrying a datapath payload and a control payload.
// The master drives the beat and the slave returns ready.
interface pipe_stage_reg_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 3
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;

   modport master (output valid, output data, output ctrl, input ready);
   modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready handshake, optional two-entry skid buffer,
// synchronous flush, and bubble semantics (ctrl reads as zero whenever the stage is empty).
module pipe_stage_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 3,
   parameter bit          SKID   = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   pipe_stage_reg_if.slave  up,
   pipe_stage_reg_if.master dn,
   output logic [1:0]       count
);

   // State doubles as the occupancy count; M is valid in ONE/TWO, S only in TWO.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            state, state_n;
   logic [DATA_W-1:0] m_data, m_data_n, s_data, s_data_n;
   logic [CTRL_W-1:0] m_ctrl, m_ctrl_n, s_ctrl, s_ctrl_n;
   logic              rdy_q, rdy_n;
   logic              m_valid, in_fire, out_fire;

   assign m_valid  = (state != EMPTY);
   assign up.ready = SKID ? rdy_q : (!m_valid || dn.ready);
   assign in_fire  = up.valid && up.ready;
   assign out_fire = m_valid && dn.ready;

   assign dn.valid = m_valid;
   assign dn.data  = m_data;
   assign dn.ctrl  = m_valid ? m_ctrl : '0;
   assign count    = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= EMPTY;
         m_data <= '0;
         m_ctrl <= '0;
         s_data <= '0;
         s_ctrl <= '0;
         rdy_q  <= 1'b1;
      end else begin
         state  <= state_n;
         m_data <= m_data_n;
         m_ctrl <= m_ctrl_n;
         s_data <= s_data_n;
         s_ctrl <= s_ctrl_n;
         rdy_q  <= rdy_n;
      end
   end

   always_comb begin
      state_n  = state;
      m_data_n = m_data;
      m_ctrl_n = m_ctrl;
      s_data_n = s_data;
      s_ctrl_n = s_ctrl;
      if (flush) begin
         state_n  = EMPTY;
         m_ctrl_n = '0;
         s_ctrl_n = '0;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  m_data_n = up.data;
                  m_ctrl_n = up.ctrl;
                  state_n  = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  m_data_n = up.data;
                  m_ctrl_n = up.ctrl;
               end else if (in_fire && SKID) begin
                  s_data_n = up.data;
                  s_ctrl_n = up.ctrl;
                  state_n  = TWO;
               end else if (out_fire) begin
                  state_n = EMPTY;
               end
            end
            TWO: begin
               if (out_fire) begin
                  m_data_n = s_data;
                  m_ctrl_n = s_ctrl;
                  s_ctrl_n = '0;
                  state_n  = ONE;
               end
            end
            default: state_n = EMPTY;
         endcase
      end
      // Registered ready: looks ahead at the next occupancy so it never depends on out_ready.
      rdy_n = (state_n != TWO);
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench driving a SKID=0 and a SKID=1 instance with identical stimulus,
// each checked against a queue-based model of an order-preserving stage of capacity 1 or 2.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        reset, flush;
   logic        iv, ordy;
   logic [31:0] idat;
   logic [2:0]  ictl;
   logic [1:0]  cnt0, cnt1;

   always #5 clk = ~clk;

   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(3)) up0 ();
   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(3)) dn0 ();
   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(3)) up1 ();
   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(3)) dn1 ();

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(3), .SKID(1'b0)) dut0 (
      .clk(clk), .reset(reset), .flush(flush), .up(up0), .dn(dn0), .count(cnt0));
   pipe_stage_reg #(.DATA_W(32), .CTRL_W(3), .SKID(1'b1)) dut1 (
      .clk(clk), .reset(reset), .flush(flush), .up(up1), .dn(dn1), .count(cnt1));

   assign up0.valid = iv;   assign up1.valid = iv;
   assign up0.data  = idat; assign up1.data  = idat;
   assign up0.ctrl  = ictl; assign up1.ctrl  = ictl;
   assign dn0.ready = ordy; assign dn1.ready = ordy;

   logic        ovld[2], irdy[2];
   logic [31:0] odat[2];
   logic [2:0]  octl[2];
   logic [1:0]  cnt[2];
   assign ovld[0] = dn0.valid; assign ovld[1] = dn1.valid;
   assign irdy[0] = up0.ready; assign irdy[1] = up1.ready;
   assign odat[0] = dn0.data;  assign odat[1] = dn1.data;
   assign octl[0] = dn0.ctrl;  assign octl[1] = dn1.ctrl;
   assign cnt[0]  = cnt0;      assign cnt[1]  = cnt1;

   // Model: beats held by each stage, head first; index 1 is the skid instance (capacity 2).
   logic [34:0] q0[$];
   logic [34:0] q1[$];
   logic        pend[2];
   logic        rdy_exp[2];
   logic        flush_prev;
   logic        mon_en;
   int          n_cmp, n_bad;

   function automatic int qsize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [34:0] qfront(input int i);
      return (i == 0) ? q0[0] : q1[0];
   endfunction

   task automatic qpush(input int i, input logic [34:0] v);
      if (i == 0) q0.push_back(v); else q1.push_back(v);
   endtask

   task automatic qpop(input int i);
      if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
   endtask

   task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s skid=%0d t=%0t got=%0h expected=%0h", name, i, $time, act, exp);
      end
   endtask

   // One stimulus cycle; a beat is pushed into the scoreboard when the model says it is accepted.
   task automatic drive(input logic v, input logic [31:0] d, input logic [2:0] c,
                        input logic o, input logic fl);
      int occ;
      @(posedge clk); #1;
      if (flush_prev) begin
         q0.delete();
         q1.delete();
      end
      iv = v; idat = d; ictl = c; ordy = o; flush = fl;
      for (int i = 0; i < 2; i++) begin
         occ = qsize(i);
         rdy_exp[i] = (i == 1) ? (occ != 2) : (occ == 0 || o);
         pend[i] = v && rdy_exp[i];
         if (pend[i]) qpush(i, {d, c});
      end
      flush_prev = fl;
   endtask

   task automatic check_reset_values();
      for (int i = 0; i < 2; i++) begin
         chk("rst_count", i, cnt[i], 0);
         chk("rst_out_valid", i, ovld[i], 0);
         chk("rst_out_ctrl", i, octl[i], 0);
         chk("rst_out_data", i, odat[i], 0);
         chk("rst_in_ready", i, irdy[i], 1);
      end
   endtask

   task automatic model_reset();
      q0.delete();
      q1.delete();
      flush_prev = 1'b0;
      for (int i = 0; i < 2; i++) begin
         pend[i] = 1'b0;
         rdy_exp[i] = 1'b1;
      end
   endtask

   // Asynchronous reset applied between edges, checked before any further clock edge.
   task automatic mid_reset();
      @(posedge clk); #1;
      iv = 1'b0; flush = 1'b0; reset = 1'b1;
      #1;
      check_reset_values();
      model_reset();
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Monitor: compares occupancy/handshake every cycle and pops the head on each output fire.
   always @(negedge clk) begin
      if (!reset && mon_en) begin
         for (int i = 0; i < 2; i++) begin
            automatic int occ = qsize(i) - int'(pend[i]);
            automatic logic [34:0] h;
            chk("count", i, cnt[i], occ);
            chk("out_valid", i, ovld[i], occ > 0);
            chk("in_ready", i, irdy[i], rdy_exp[i]);
            if (ovld[i] && occ > 0) begin
               h = qfront(i);
               chk("out_data", i, odat[i], h[34:3]);
               chk("out_ctrl", i, octl[i], h[2:0]);
               if (ordy) qpop(i);
            end else if (!ovld[i]) begin
               chk("bubble_ctrl", i, octl[i], 0);
            end
         end
      end
   end

   initial begin
      n_cmp = 0; n_bad = 0; mon_en = 1'b0;
      iv = 1'b0; idat = '0; ictl = '0; ordy = 1'b0; flush = 1'b0;
      model_reset();
      reset = 1'b1;
      #2;
      check_reset_values();
      @(posedge clk); #1;
      reset = 1'b0;
      mon_en = 1'b1;

      // Streaming at full rate
      drive(1'b1, 32'h11, 3'd1, 1'b1, 1'b0);
      drive(1'b1, 32'h22, 3'd2, 1'b1, 1'b0);
      drive(1'b1, 32'h33, 3'd3, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

      // Fill under backpressure, then flush with a beat offered in the same cycle
      drive(1'b1, 32'hA, 3'b101, 1'b0, 1'b0);
      drive(1'b1, 32'hB, 3'b101, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
      drive(1'b1, 32'hC, 3'b010, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

      // Backpressure then release: drain order and ready recovery
      drive(1'b1, 32'hA, 3'b101, 1'b0, 1'b0);
      drive(1'b1, 32'hB, 3'b110, 1'b0, 1'b0);
      drive(1'b1, 32'hD, 3'b011, 1'b0, 1'b0);
      drive(1'b1, 32'hE, 3'b001, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

      // Flush while full with the head being delivered
      drive(1'b1, 32'h44, 3'd4, 1'b0, 1'b0);
      drive(1'b1, 32'h55, 3'd5, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b1);
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

      // Bubble: ctrl offered while empty must not leak before the stage is valid
      drive(1'b1, 32'h77, 3'b111, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

      // Reset mid-stream with the skid instance full
      drive(1'b1, 32'h66, 3'd6, 1'b0, 1'b0);
      drive(1'b1, 32'h67, 3'd7, 1'b0, 1'b0);
      drive(1'b1, 32'h68, 3'd1, 1'b0, 1'b0);
      mid_reset();
      drive(1'b1, 32'h99, 3'd2, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

      // Randomized traffic with alternating backpressure regimes and sparse flushes
      for (int n = 0; n < 800; n++) begin
         automatic logic o;
         if (n == 400) mid_reset();
         case ((n / 100) % 4)
            0:       o = 1'b1;
            1:       o = ($urandom_range(0, 3) == 0);
            2:       o = ($urandom_range(0, 1) == 0);
            default: o = ($urandom_range(0, 3) != 0);
         endcase
         drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)), o,
               $urandom_range(0, 24) == 0);
      end
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces fixed-width flush-only stage registers with a single block that has a valid/ready handshake, an optional two-entry skid buffer, synchronous flush, and bubble semantics. Bubble semantics means the control fields are zero whenever the stage holds no valid instruction. Every pipeline boundary in the core instantiates it, with payload and control widths set per stage.

## Interface
Parameters:
- DATA_W, 32, width of datapath payload (e.g. MemData, ALUOut, WriteReg packed).
- CTRL_W, 3, width of control payload (e.g. RegWrite, MemtoReg); forced to 0 on bubbles.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-high; clears all state immediately.
- flush, input, 1, synchronous kill of all held entries and of any beat accepted this cycle.
- in_valid, input, 1, upstream beat present.
- in_ready, output, 1, block can accept a beat this cycle.
- in_data, input, DATA_W, upstream datapath payload.
- in_ctrl, input, CTRL_W, upstream control payload.
- out_valid, output, 1, head entry valid.
- out_ready, input, 1, downstream accepts head this cycle.
- out_data, output, DATA_W, head datapath payload.
- out_ctrl, output, CTRL_W, head control payload; 0 when out_valid=0.
- count, output, 2, number of valid entries (0..2; max 1 when SKID=0).

## Operation
- Input fire = in_valid && in_ready. Output fire = out_valid && out_ready.
- Storage:
  - Main entry M drives out_*.
  - Skid entry S exists only when SKID=1.
  - Each entry holds data, ctrl and a valid bit.
- SKID=1 state machine, encoded by count:
  - EMPTY (0):
    - Input fire -> M loads the input; go to ONE.
  - ONE (1):
    - Input fire and output fire -> M reloads from the input; stay in ONE.
    - Input fire and no output fire -> S loads the input; go to TWO.
    - Output fire only -> go to EMPTY.
  - TWO (2):
    - in_ready=0, so no input fire is possible.
    - Output fire -> M loads from S, S is invalidated; go to ONE.
- in_ready for SKID=1 is a registered signal, equal to count!=2. It has no combinational path from out_ready.
- SKID=0:
  - Single entry M.
  - in_ready = !out_valid || out_ready, combinational.
  - Input fire loads M. Output fire without input fire empties M.
- Ordering is strictly FIFO. No beat is duplicated or lost except by flush.
- Flush has highest priority after reset. On the next edge:
  - All entries are invalidated; count becomes 0.
  - An input beat firing in the same cycle is consumed and discarded.
  - An output fire in the same cycle counts as delivered downstream.
- Bubble rule:
  - out_ctrl = 0 whenever out_valid=0, enforced combinationally from the valid bit.
  - Stored ctrl is also cleared on flush.
  - out_data is don't-care when invalid and holds its last value.

## Timing
- Reset (asynchronous) values:
  - out_valid=0, out_ctrl=0, out_data=0, count=0.
  - in_ready=1, internal S valid=0.
- Latency: beat accepted at edge N is presented on out_* after edge N (one cycle).
- Throughput: one beat per cycle sustained while out_ready=1, for both SKID values.
- SKID=1 backpressure:
  - out_ready low with continuous input: count reaches 2 after two fires; in_ready falls the cycle after the second fire.
  - After out_ready rises: in_ready returns 1 the cycle after the first drain.
- Flush while count=2 and out_ready=1: the head is delivered; S is discarded.
- Reset asserted mid-transfer: outputs clear immediately, without waiting for clk. The first fire after deassertion is accepted normally.
- No combinational path from in_* to out_*. SKID=1 additionally has no path from out_ready to in_ready.

## Test plan
- Reset: assert reset mid-stream with count=2 -> out_valid=0, out_ctrl=0, count=0, in_ready=1 before the next edge.
- Streaming (SKID=1): beats 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 -> out_data 0x11, 0x22, 0x33 on the following consecutive cycles, count=1 throughout.
- Backpressure (SKID=1):
  - Hold out_ready=0 and send 0xA, 0xB -> count=2 and in_ready=0.
  - Release out_ready -> outputs 0xA then 0xB in order; in_ready=1 one cycle after the first drain.
- Flush:
  - Hold count=2 with ctrl=3'b101, then pulse flush with in_valid=1 and beat 0xC -> next cycle out_valid=0, out_ctrl=0, count=0.
  - 0xC never appears at the output.
- SKID=0: with out_valid=1 and out_ready=0, in_ready=0; raising out_ready raises in_ready in the same cycle, and a new beat replaces the head at the next edge.
- Bubble: in_valid=1 with in_ctrl=3'b111 while out_valid=0 -> out_ctrl stays 0 until the edge where out_valid rises.
